// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

    localparam int P_CPU = 0;
    localparam int P_DMA = 1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request and response handshakes.
interface dmem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU LSU (port 0) and the
// DMA/debug loader (port 1); one transaction in flight at a time.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int DEPTH   = 32,
    parameter int MEM_LAT = 0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic           mem_we,
    output logic           mem_re,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);
    state_t        state_q, state_d;
    logic          owner_q, last_grant_q, we_q, err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic [1:0]    gnt;
    logic          in_range, rsp_ready;

    rr_arb2 u_arb (
        .req        ({p1.req_valid, p0.req_valid}),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .gnt        (gnt)
    );

    assign in_range  = 32'(addr_q) < 32'(DEPTH);
    assign rsp_ready = owner_q ? p1.rsp_ready : p0.rsp_ready;

    assign p0.req_ready = gnt[P_CPU];
    assign p1.req_ready = gnt[P_DMA];

    // Response payload is zeroed on the port that does not own the transaction.
    assign p0.rsp_valid = (state_q == RESP) && (owner_q == 1'(P_CPU));
    assign p1.rsp_valid = (state_q == RESP) && (owner_q == 1'(P_DMA));
    assign p0.rsp_rdata = p0.rsp_valid ? rdata_q : '0;
    assign p1.rsp_rdata = p1.rsp_valid ? rdata_q : '0;
    assign p0.rsp_err   = p0.rsp_valid & err_q;
    assign p1.rsp_err   = p1.rsp_valid & err_q;

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE:    if (|gnt) state_d = ACCESS;
            ACCESS: begin
                if (in_range) begin
                    mem_we    = we_q;
                    mem_re    = !we_q;
                    mem_addr  = addr_q;
                    mem_wdata = we_q ? wdata_q : '0;
                end
                state_d = (in_range && !we_q && MEM_LAT == 1) ? RD_WAIT : RESP;
            end
            RD_WAIT: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (|gnt) begin
                    owner_q      <= gnt[P_DMA];
                    last_grant_q <= gnt[P_DMA];
                    we_q         <= gnt[P_DMA] ? p1.req_we    : p0.req_we;
                    addr_q       <= gnt[P_DMA] ? p1.req_addr  : p0.req_addr;
                    wdata_q      <= gnt[P_DMA] ? p1.req_wdata : p0.req_wdata;
                    rdata_q      <= '0;
                    err_q        <= 1'b0;
                end
                ACCESS: begin
                    if (!in_range) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (!we_q && MEM_LAT == 0) begin
                        rdata_q <= mem_rdata;
                    end
                end
                RD_WAIT: rdata_q <= mem_rdata;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance per memory latency, directed steps
// with a response scoreboard.
module tb_dmem_arbiter;
    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Flat port index: dut*2 + port
    logic [3:0]       req_valid, req_we, rsp_ready;
    logic [3:0][5:0]  req_addr;
    logic [3:0][31:0] req_wdata;
    logic [3:0]       req_ready, rsp_valid, rsp_err;
    logic [3:0][31:0] rsp_rdata;

    logic [1:0]       mem_we, mem_re;
    logic [1:0][5:0]  mem_addr;
    logic [1:0][31:0] mem_wdata;
    logic [31:0]      mem_rdata0, mem_rdata1;
    logic [31:0]      mem0 [32];
    logic [31:0]      mem1 [32];

    dmem_arbiter_if #(.AW(6), .DW(32)) ifc [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_if
        assign ifc[g].req_valid = req_valid[g];
        assign ifc[g].req_we    = req_we[g];
        assign ifc[g].req_addr  = req_addr[g];
        assign ifc[g].req_wdata = req_wdata[g];
        assign ifc[g].rsp_ready = rsp_ready[g];
        assign req_ready[g]     = ifc[g].req_ready;
        assign rsp_valid[g]     = ifc[g].rsp_valid;
        assign rsp_rdata[g]     = ifc[g].rsp_rdata;
        assign rsp_err[g]       = ifc[g].rsp_err;
    end

    dmem_arbiter #(.AW(6), .DW(32), .DEPTH(32), .MEM_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .p0(ifc[0]), .p1(ifc[1]),
        .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata0)
    );

    dmem_arbiter #(.AW(6), .DW(32), .DEPTH(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .p0(ifc[2]), .p1(ifc[3]),
        .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata1)
    );

    assign mem_rdata0 = mem0[mem_addr[0][4:0]];

    always @(posedge clk) begin
        if (mem_we[0]) mem0[mem_addr[0][4:0]] <= mem_wdata[0];
        if (mem_we[1]) mem1[mem_addr[1][4:0]] <= mem_wdata[1];
        if (mem_re[1]) mem_rdata1 <= mem1[mem_addr[1][4:0]];
    end

    int         we_cnt [2];
    int         re_cnt [2];
    logic [5:0] last_addr [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) begin
                we_cnt[d]    <= we_cnt[d] + 1;
                last_addr[d] <= mem_addr[d];
            end
            if (mem_re[d]) begin
                re_cnt[d]    <= re_cnt[d] + 1;
                last_addr[d] <= mem_addr[d];
            end
        end
    end

    int   total = 0;
    int   passed = 0;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction on dut d, port p; checks latency, payload and strobes.
    task automatic do_txn(input int d, input int p, input logic we, input logic [5:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input string tag);
        int   i, n, we0, re0;
        exp_t e;
        i   = d * 2 + p;
        we0 = we_cnt[d];
        re0 = re_cnt[d];
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
        if (!req_ready[i]) begin
            chk({tag, "_accept"}, 64'(req_ready[i]), 64'd1);
            req_valid[i] = 1'b0;
            return;
        end
        sb.push_back('{p, exp_rd, exp_err});
        @(negedge clk);
        req_valid[i] = 1'b0;
        n = 1;
        #1;
        while (!rsp_valid[i] && n < 20) begin @(negedge clk); #1; n++; end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        e = sb.pop_front();
        chk({tag, "_rdata"}, 64'(rsp_rdata[i]), 64'(e.rdata));
        chk({tag, "_err"}, 64'(rsp_err[i]), 64'(e.err));
        @(negedge clk);
        #1;
        chk({tag, "_rsp_drop"}, 64'(rsp_valid[i]), 64'd0);
        chk({tag, "_we_cnt"}, 64'(we_cnt[d] - we0), 64'(we && !exp_err));
        chk({tag, "_re_cnt"}, 64'(re_cnt[d] - re0), 64'(!we && !exp_err));
        if (!exp_err) chk({tag, "_addr"}, 64'(last_addr[d]), 64'(addr));
    endtask

    initial begin : main
        int   n, grants, resps;
        int   order [$];
        exp_t e;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '1;
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        do_txn(0, 0, 1'b1, 6'd3, 32'hDEADBEEF, 32'd0, 1'b0, 2, "w0");
        do_txn(0, 0, 1'b0, 6'd3, 32'd0, 32'hDEADBEEF, 1'b0, 2, "r0");
        do_txn(1, 0, 1'b1, 6'd3, 32'hDEADBEEF, 32'd0, 1'b0, 2, "w1");
        do_txn(1, 0, 1'b0, 6'd3, 32'd0, 32'hDEADBEEF, 1'b0, 3, "r1");
        do_txn(0, 1, 1'b0, 6'd40, 32'd0, 32'd0, 1'b1, 2, "oor40");
        do_txn(0, 0, 1'b1, 6'd32, 32'h1234, 32'd0, 1'b1, 2, "oor32");
        do_txn(0, 1, 1'b1, 6'd31, 32'hCAFE0031, 32'd0, 1'b0, 2, "w31");
        do_txn(0, 0, 1'b0, 6'd31, 32'd0, 32'hCAFE0031, 1'b0, 2, "r31");

        // Both ports hammering: grants must alternate starting with port 0.
        @(negedge clk);
        do_reset();
        req_we[0] = 1'b1; req_addr[0] = 6'd10; req_wdata[0] = 32'hA0A0A0A0;
        req_we[1] = 1'b1; req_addr[1] = 6'd11; req_wdata[1] = 32'hB1B1B1B1;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        grants = 0; resps = 0; n = 0;
        while (resps < 4 && n < 60) begin
            #1;
            if (grants < 4) begin
                if (req_ready[0]) begin order.push_back(0); sb.push_back('{0, 32'd0, 1'b0}); grants++; end
                else if (req_ready[1]) begin order.push_back(1); sb.push_back('{1, 32'd0, 1'b0}); grants++; end
            end
            if (rsp_valid[0] || rsp_valid[1]) begin
                e = sb.pop_front();
                chk("rr_rsp_port", 64'(rsp_valid[1]), 64'(e.port));
                chk("rr_rsp_rdata", 64'(rsp_rdata[e.port]), 64'(e.rdata));
                resps++;
            end
            @(negedge clk);
            n++;
            if (grants >= 4) begin req_valid[0] = 1'b0; req_valid[1] = 1'b0; end
        end
        chk("rr_resps", 64'(resps), 64'd4);
        chk("rr_grants", 64'(order.size()), 64'd4);
        for (int k = 0; k < order.size(); k++) chk("rr_order", 64'(order[k]), 64'(k % 2));
        chk("rr_mem10", 64'(mem0[10]), 64'hA0A0A0A0);
        chk("rr_mem11", 64'(mem0[11]), 64'hB1B1B1B1);

        // Response held for 5 cycles blocks port 1.
        @(negedge clk);
        do_reset();
        req_we[0] = 1'b0; req_addr[0] = 6'd3; rsp_ready[0] = 1'b0; req_valid[0] = 1'b1;
        req_we[1] = 1'b1; req_addr[1] = 6'd5; req_wdata[1] = 32'h55; req_valid[1] = 1'b1;
        #1;
        chk("hold_grant", 64'(req_ready[1:0]), 64'b01);
        sb.push_back('{0, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 1;
        #1;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); #1; n++; end
        chk("hold_lat", 64'(n), 64'd2);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 64'(rsp_valid[0]), 64'd1);
            chk("hold_rdata", 64'(rsp_rdata[0]), 64'(e.rdata));
            chk("hold_p1_ready", 64'(req_ready[1]), 64'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("hold_release", 64'(rsp_valid[0]), 64'd0);
        chk("hold_p1_grant", 64'(req_ready[1]), 64'd1);
        sb.push_back('{1, 32'd0, 1'b0});
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 1;
        #1;
        while (!rsp_valid[1] && n < 20) begin @(negedge clk); #1; n++; end
        e = sb.pop_front();
        chk("hold_p1_lat", 64'(n), 64'd2);
        chk("hold_p1_rdata", 64'(rsp_rdata[1]), 64'(e.rdata));
        chk("hold_p1_err", 64'(rsp_err[1]), 64'(e.err));
        @(negedge clk);

        // Reset during RD_WAIT on the latency-1 instance.
        req_we[2] = 1'b0; req_addr[2] = 6'd3; req_valid[2] = 1'b1;
        #1;
        chk("rdw_accept", 64'(req_ready[2]), 64'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        chk("rdw_access_re", 64'(mem_re[1]), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rdw_no_rsp", 64'(rsp_valid[3:2]), 64'd0);
        chk("rdw_strobes", 64'({mem_we[1], mem_re[1]}), 64'd0);
        reset = 1'b0;
        req_we[3] = 1'b0; req_addr[3] = 6'd3;
        req_valid[2] = 1'b1; req_valid[3] = 1'b1;
        #1;
        chk("rdw_p0_first", 64'(req_ready[3:2]), 64'b01);
        @(negedge clk);
        req_valid[2] = 1'b0; req_valid[3] = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
